// File: rtl/gamma_corrector_pkg.sv
// Shared definitions for the gamma correction stage.
//   lut_ch_e    : table write target select (single channel or broadcast)
//   tdata_width : AXI4-Stream TDATA width for a given component width,
//                 3 components rounded up to whole bytes
package gamma_corrector_pkg;

    typedef enum logic [1:0] {
        CH_R   = 2'd0,
        CH_G   = 2'd1,
        CH_B   = 2'd2,
        CH_ALL = 2'd3
    } lut_ch_e;

    function automatic int unsigned tdata_width(input int unsigned px_width);
        return ((3 * px_width + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle. tuser is a single start-of-frame flag.
//   master : drives tvalid/tdata/sidebands, receives tready
//   slave  : receives tvalid/tdata/sidebands, drives tready
interface axi4_stream_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DEST_W = 4
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic [DATA_W/8-1:0]   tstrb;
    logic                  tlast;
    logic                  tuser;
    logic [ID_W-1:0]       tid;
    logic [DEST_W-1:0]     tdest;

    modport master (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
                    input  tready);
    modport slave  (input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
                    output tready);
endinterface

// File: rtl/gamma_lut_ram.sv
// One channel's double-banked tone curve: 2 x 2^PX_WIDTH entries of PX_WIDTH
// bits, addressed by {bank, index}. Contents come up as identity in both banks.
//   clk_i     : clock
//   wr_en_i   : write strobe; wr_addr_i / wr_data_i select entry and value
//   rd_en_i   : read enable; rd_addr_i sampled, rd_data_o valid next cycle
module gamma_lut_ram #(
    parameter int unsigned PX_WIDTH = 10
) (
    input  logic                clk_i,
    input  logic                wr_en_i,
    input  logic [PX_WIDTH:0]   wr_addr_i,
    input  logic [PX_WIDTH-1:0] wr_data_i,
    input  logic                rd_en_i,
    input  logic [PX_WIDTH:0]   rd_addr_i,
    output logic [PX_WIDTH-1:0] rd_data_o
);
    localparam int unsigned DEPTH = 2 ** (PX_WIDTH + 1);

    typedef logic [PX_WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t identity_fill();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i] = PX_WIDTH'(i);
        end
        return m;
    endfunction

    mem_t mem = identity_fill();

    logic [PX_WIDTH-1:0] rd_data_d;
    logic [PX_WIDTH-1:0] rd_data_q;

    // Write-first on an address collision: a write and a bank swap in the
    // same cycle must be visible to the beat that triggers the swap.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_d = wr_data_i;
            end else begin
                rd_data_d = mem[rd_addr_i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gamma_corrector.sv
// Per-channel gamma / tone-curve stage on an RGB AXI4-Stream.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   lut_wr_i ...     : shadow-bank table write port (lut_ch_i 3 = broadcast)
//   lut_commit_i     : request bank swap at the next start of frame
//   bypass_i         : pass-through request, sampled on each SOF
//   lut_pending_o    : commit requested, swap not yet taken
//   video_i/video_o  : RGB stream in/out, 2-cycle pipeline
module gamma_corrector
    import gamma_corrector_pkg::*;
#(
    parameter int unsigned PX_WIDTH = 10,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned DEST_W   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                lut_wr_i,
    input  logic [1:0]          lut_ch_i,
    input  logic [PX_WIDTH-1:0] lut_addr_i,
    input  logic [PX_WIDTH-1:0] lut_data_i,
    input  logic                lut_commit_i,
    input  logic                bypass_i,
    output logic                lut_pending_o,
    axi4_stream_if.slave        video_i,
    axi4_stream_if.master       video_o
);
    localparam int unsigned TDATA_W = tdata_width(PX_WIDTH);
    localparam int unsigned KEEP_W  = TDATA_W / 8;
    localparam int unsigned PIX_W   = 3 * PX_WIDTH;

    logic active_bank_q, active_bank_d;
    logic pending_q,     pending_d;
    logic bypass_q,      bypass_d;

    logic                s1_valid_q,  s1_valid_d;
    logic                s1_bypass_q, s1_bypass_d;
    logic [PIX_W-1:0]    s1_pix_q,    s1_pix_d;
    logic                s1_last_q,   s1_last_d;
    logic                s1_user_q,   s1_user_d;
    logic [ID_W-1:0]     s1_id_q,     s1_id_d;
    logic [DEST_W-1:0]   s1_dest_q,   s1_dest_d;
    logic [KEEP_W-1:0]   s1_keep_q,   s1_keep_d;
    logic [KEEP_W-1:0]   s1_strb_q,   s1_strb_d;

    logic                out_valid_q, out_valid_d;
    logic [TDATA_W-1:0]  out_data_q,  out_data_d;
    logic                out_last_q,  out_last_d;
    logic                out_user_q,  out_user_d;
    logic [ID_W-1:0]     out_id_q,    out_id_d;
    logic [DEST_W-1:0]   out_dest_q,  out_dest_d;
    logic [KEEP_W-1:0]   out_keep_q,  out_keep_d;
    logic [KEEP_W-1:0]   out_strb_q,  out_strb_d;

    logic                en, accept, sof, commit_eff, swap, beat_bank, beat_bypass;
    logic                wr_ok, wr_r, wr_g, wr_b;
    logic [PX_WIDTH-1:0] lut_r, lut_g, lut_b;
    lut_ch_e             ch;
    logic                unused_pad;

    assign en          = !out_valid_q || video_o.tready;
    assign accept      = video_i.tvalid && en;
    assign sof         = accept && video_i.tuser;
    assign commit_eff  = pending_q || lut_commit_i;
    assign swap        = sof && commit_eff;
    // Bank and bypass are resolved for the accepted beat itself, so the SOF
    // beat already sees the post-swap curve and freshly sampled bypass.
    assign beat_bank   = active_bank_q ^ swap;
    assign beat_bypass = sof ? bypass_i : bypass_q;

    assign ch    = lut_ch_e'(lut_ch_i);
    assign wr_ok = lut_wr_i && !rst_i;
    assign wr_r  = wr_ok && (ch == CH_R || ch == CH_ALL);
    assign wr_g  = wr_ok && (ch == CH_G || ch == CH_ALL);
    assign wr_b  = wr_ok && (ch == CH_B || ch == CH_ALL);

    assign unused_pad = |(video_i.tdata >> PIX_W);

    gamma_lut_ram #(.PX_WIDTH(PX_WIDTH)) u_ram_r (
        .clk_i     (clk_i),
        .wr_en_i   (wr_r),
        .wr_addr_i ({!active_bank_q, lut_addr_i}),
        .wr_data_i (lut_data_i),
        .rd_en_i   (en),
        .rd_addr_i ({beat_bank, video_i.tdata[3*PX_WIDTH-1:2*PX_WIDTH]}),
        .rd_data_o (lut_r)
    );

    gamma_lut_ram #(.PX_WIDTH(PX_WIDTH)) u_ram_g (
        .clk_i     (clk_i),
        .wr_en_i   (wr_g),
        .wr_addr_i ({!active_bank_q, lut_addr_i}),
        .wr_data_i (lut_data_i),
        .rd_en_i   (en),
        .rd_addr_i ({beat_bank, video_i.tdata[PX_WIDTH-1:0]}),
        .rd_data_o (lut_g)
    );

    gamma_lut_ram #(.PX_WIDTH(PX_WIDTH)) u_ram_b (
        .clk_i     (clk_i),
        .wr_en_i   (wr_b),
        .wr_addr_i ({!active_bank_q, lut_addr_i}),
        .wr_data_i (lut_data_i),
        .rd_en_i   (en),
        .rd_addr_i ({beat_bank, video_i.tdata[2*PX_WIDTH-1:PX_WIDTH]}),
        .rd_data_o (lut_b)
    );

    always_comb begin
        active_bank_d = active_bank_q ^ swap;
        pending_d     = commit_eff && !swap;
        bypass_d      = sof ? bypass_i : bypass_q;

        s1_valid_d  = s1_valid_q;
        s1_bypass_d = s1_bypass_q;
        s1_pix_d    = s1_pix_q;
        s1_last_d   = s1_last_q;
        s1_user_d   = s1_user_q;
        s1_id_d     = s1_id_q;
        s1_dest_d   = s1_dest_q;
        s1_keep_d   = s1_keep_q;
        s1_strb_d   = s1_strb_q;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        out_id_d    = out_id_q;
        out_dest_d  = out_dest_q;
        out_keep_d  = out_keep_q;
        out_strb_d  = out_strb_q;

        if (en) begin
            s1_valid_d  = video_i.tvalid;
            s1_bypass_d = beat_bypass;
            s1_pix_d    = video_i.tdata[PIX_W-1:0];
            s1_last_d   = video_i.tlast;
            s1_user_d   = video_i.tuser;
            s1_id_d     = video_i.tid;
            s1_dest_d   = video_i.tdest;
            s1_keep_d   = video_i.tkeep;
            s1_strb_d   = video_i.tstrb;

            out_valid_d = s1_valid_q;
            out_data_d  = s1_bypass_q ? TDATA_W'(s1_pix_q)
                                      : TDATA_W'({lut_r, lut_b, lut_g});
            out_last_d  = s1_last_q;
            out_user_d  = s1_user_q;
            out_id_d    = s1_id_q;
            out_dest_d  = s1_dest_q;
            out_keep_d  = s1_keep_q;
            out_strb_d  = s1_strb_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_bank_q <= 1'b0;
            pending_q     <= 1'b0;
            bypass_q      <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_bypass_q   <= 1'b0;
            s1_pix_q      <= '0;
            s1_last_q     <= 1'b0;
            s1_user_q     <= 1'b0;
            s1_id_q       <= '0;
            s1_dest_q     <= '0;
            s1_keep_q     <= '0;
            s1_strb_q     <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_user_q    <= 1'b0;
            out_id_q      <= '0;
            out_dest_q    <= '0;
            out_keep_q    <= '0;
            out_strb_q    <= '0;
        end else begin
            active_bank_q <= active_bank_d;
            pending_q     <= pending_d;
            bypass_q      <= bypass_d;
            s1_valid_q    <= s1_valid_d;
            s1_bypass_q   <= s1_bypass_d;
            s1_pix_q      <= s1_pix_d;
            s1_last_q     <= s1_last_d;
            s1_user_q     <= s1_user_d;
            s1_id_q       <= s1_id_d;
            s1_dest_q     <= s1_dest_d;
            s1_keep_q     <= s1_keep_d;
            s1_strb_q     <= s1_strb_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            out_user_q    <= out_user_d;
            out_id_q      <= out_id_d;
            out_dest_q    <= out_dest_d;
            out_keep_q    <= out_keep_d;
            out_strb_q    <= out_strb_d;
        end
    end

    assign video_i.tready = en;
    assign video_o.tvalid = out_valid_q;
    assign video_o.tdata  = out_data_q;
    assign video_o.tlast  = out_last_q;
    assign video_o.tuser  = out_user_q;
    assign video_o.tid    = out_id_q;
    assign video_o.tdest  = out_dest_q;
    assign video_o.tkeep  = out_keep_q;
    assign video_o.tstrb  = out_strb_q;
    assign lut_pending_o  = pending_q;

endmodule

// File: tb/tb_gamma_corrector.sv
module tb_gamma_corrector;
    import gamma_corrector_pkg::*;

    localparam int unsigned PXW = 10;
    localparam int unsigned DW  = tdata_width(PXW);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, lut_wr, lut_commit, bypass, lut_pending;
    logic [1:0]     lut_ch;
    logic [PXW-1:0] lut_addr, lut_data;

    axi4_stream_if #(.DATA_W(DW), .ID_W(4), .DEST_W(4)) vin ();
    axi4_stream_if #(.DATA_W(DW), .ID_W(4), .DEST_W(4)) vout ();

    gamma_corrector #(.PX_WIDTH(PXW), .ID_W(4), .DEST_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .lut_wr_i     (lut_wr),
        .lut_ch_i     (lut_ch),
        .lut_addr_i   (lut_addr),
        .lut_data_i   (lut_data),
        .lut_commit_i (lut_commit),
        .bypass_i     (bypass),
        .lut_pending_o(lut_pending),
        .video_i      (vin),
        .video_o      (vout)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [17:0]   side;
    } beat_t;

    logic [17:0] side_i, side_o;
    assign side_i = {vin.tlast, vin.tuser, vin.tid, vin.tdest, vin.tkeep, vin.tstrb};
    assign side_o = {vout.tlast, vout.tuser, vout.tid, vout.tdest, vout.tkeep, vout.tstrb};

    // Reference: curves[channel][bank][index], channel 0=R 1=G 2=B
    int          tbl [3][2][1024];
    bit          m_bank, m_pending, m_bypass;
    beat_t       exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    bit          acc_last, held_v;
    logic [DW-1:0] held_data, last_out;
    logic [17:0] held_side;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] map_beat(input logic [DW-1:0] d);
        logic [PXW-1:0] r, g, b;
        if (m_bypass) return DW'(d[29:0]);
        r = PXW'(tbl[0][m_bank][d[29:20]]);
        g = PXW'(tbl[1][m_bank][d[9:0]]);
        b = PXW'(tbl[2][m_bank][d[19:10]]);
        return DW'({r, b, g});
    endfunction

    task automatic tick();
        bit pend;
        beat_t e;
        @(negedge clk);
        if (held_v) begin
            chk("hold_valid", vout.tvalid, 1);
            chk("hold_data", vout.tdata, held_data);
            chk("hold_side", side_o, held_side);
        end
        held_v = 0;
        if (vout.tvalid) begin
            if (vout.tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", vout.tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", vout.tdata, e.data);
                    chk("side", side_o, e.side);
                    last_out = vout.tdata;
                    pops++;
                end
            end else begin
                held_v    = 1;
                held_data = vout.tdata;
                held_side = side_o;
            end
        end
        chk("pending", lut_pending, m_pending);
        chk("tready", vin.tready, !vout.tvalid || vout.tready);
        acc_last = 0;
        if (rst) begin
            m_pending = 0;
            m_bank    = 0;
            m_bypass  = 0;
            exp_q.delete();
            held_v    = 0;
        end else begin
            if (lut_wr) begin
                for (int c = 0; c < 3; c++) begin
                    if (lut_ch == 2'd3 || int'(lut_ch) == c) tbl[c][!m_bank][lut_addr] = int'(lut_data);
                end
            end
            acc_last = vin.tvalid && vin.tready;
            pend = m_pending || lut_commit;
            if (acc_last && vin.tuser) begin
                if (pend) begin
                    m_bank = !m_bank;
                    pend   = 0;
                end
                m_bypass = bypass;
            end
            m_pending = pend;
            if (acc_last) exp_q.push_back('{data: map_beat(vin.tdata), side: side_i});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [PXW-1:0] r, input logic [PXW-1:0] g,
                            input logic [PXW-1:0] b, input logic sof);
        vin.tvalid = 1;
        vin.tdata  = {2'b00, r, b, g};
        vin.tuser  = sof;
        vin.tlast  = 1'($urandom);
        vin.tid    = 4'($urandom);
        vin.tdest  = 4'($urandom);
        vin.tkeep  = 4'($urandom);
        vin.tstrb  = 4'($urandom);
    endtask

    task automatic send_beat(input logic [PXW-1:0] r, input logic [PXW-1:0] g,
                             input logic [PXW-1:0] b, input logic sof);
        int n = 0;
        set_beat(r, g, b, sof);
        do begin
            tick();
            n++;
        end while (!acc_last && n < 50);
        chk("accept", acc_last, 1);
        vin.tvalid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic write_inverted(input logic [1:0] ch);
        for (int i = 0; i < 1024; i++) begin
            lut_wr   = 1;
            lut_ch   = ch;
            lut_addr = PXW'(i);
            lut_data = PXW'(1023 - i);
            tick();
        end
        lut_wr = 0;
    endtask

    initial begin
        int p0;
        int beats;
        int cyc;
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 1024; i++) tbl[c][k][i] = i;
        rst = 1; lut_wr = 0; lut_ch = 0; lut_addr = 0; lut_data = 0;
        lut_commit = 0; bypass = 0;
        vin.tvalid = 0; vin.tdata = '0; vin.tuser = 0; vin.tlast = 0;
        vin.tid = '0; vin.tdest = '0; vin.tkeep = '0; vin.tstrb = '0;
        vout.tready = 1;
        m_bank = 0; m_pending = 0; m_bypass = 0; held_v = 0; acc_last = 0;
        last_out = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", vout.tvalid, 0);
        chk("rst_tdata", vout.tdata, 0);
        chk("rst_tready", vin.tready, 1);
        chk("rst_pending", lut_pending, 0);
        tick();
        rst = 0;
        tick();

        // Identity after reset, two-cycle latency
        p0 = pops;
        set_beat(10'd100, 10'd200, 10'd300, 1'b1);
        tick();
        chk("accept0", acc_last, 1);
        vin.tvalid = 0;
        tick();
        chk("lat_n1", pops, p0);
        tick();
        chk("lat_n2", pops, p0 + 1);
        chk("identity", last_out, {2'b00, 10'd100, 10'd300, 10'd200});

        // Inverted broadcast curve, commit mid-frame
        write_inverted(2'd3);
        send_beat(10'd5, 10'd6, 10'd7, 1'b1);
        send_beat(10'd100, 10'd100, 10'd100, 1'b0);
        lut_commit = 1;
        tick();
        lut_commit = 0;
        tick();
        chk("pend_set", lut_pending, 1);
        send_beat(10'd100, 10'd100, 10'd100, 1'b0);
        drain();
        chk("midframe_r", last_out[29:20], 100);
        send_beat(10'd100, 10'd200, 10'd300, 1'b1);
        drain();
        chk("inv_r", last_out[29:20], 923);
        chk("pend_clr", lut_pending, 0);

        // Single-channel write on top of a rewritten inverted curve
        write_inverted(2'd3);
        lut_wr = 1; lut_ch = 2'd1; lut_addr = 10'd50; lut_data = 10'd7;
        tick();
        lut_wr = 0;
        lut_commit = 1;
        tick();
        lut_commit = 0;
        send_beat(10'd50, 10'd50, 10'd50, 1'b1);
        drain();
        chk("single_g", last_out[9:0], 7);
        chk("single_r", last_out[29:20], 973);
        chk("single_b", last_out[19:10], 973);

        // Bypass takes effect only at the next SOF
        send_beat(10'd10, 10'd20, 10'd30, 1'b0);
        bypass = 1;
        send_beat(10'd10, 10'd20, 10'd30, 1'b0);
        drain();
        chk("byp_mid", last_out[29:20], 1013);
        send_beat(10'd10, 10'd20, 10'd30, 1'b1);
        drain();
        chk("byp_on", last_out, {2'b00, 10'd10, 10'd30, 10'd20});
        bypass = 0;
        send_beat(10'd10, 10'd20, 10'd30, 1'b1);
        drain();
        chk("byp_off", last_out[29:20], 1013);

        // Reset mid-frame with a pending commit and a stalled pipe
        lut_wr = 1; lut_ch = 2'd1; lut_addr = 10'd50; lut_data = 10'd9;
        tick();
        lut_wr = 0;
        lut_commit = 1;
        tick();
        lut_commit = 0;
        vout.tready = 0;
        send_beat(10'd1, 10'd2, 10'd3, 1'b0);
        send_beat(10'd4, 10'd5, 10'd6, 1'b0);
        tick();
        chk("mrst_pend_pre", lut_pending, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("mrst_tvalid", vout.tvalid, 0);
        chk("mrst_pending", lut_pending, 0);
        vout.tready = 1;
        send_beat(10'd50, 10'd50, 10'd50, 1'b1);
        drain();
        chk("mrst_bank0_g", last_out[9:0], 7);
        chk("mrst_bank0_r", last_out[29:20], 973);

        // Random traffic with backpressure, table writes and commits
        beats = 0;
        cyc   = 0;
        while (beats < 1000 && cyc < 20000) begin
            vout.tready = ($urandom_range(0, 3) != 0);
            if (!vin.tvalid || acc_last) begin
                vin.tvalid = ($urandom_range(0, 3) != 0);
                vin.tdata  = DW'($urandom);
                vin.tuser  = ($urandom_range(0, 39) == 0);
                vin.tlast  = 1'($urandom);
                vin.tid    = 4'($urandom);
                vin.tdest  = 4'($urandom);
                vin.tkeep  = 4'($urandom);
                vin.tstrb  = 4'($urandom);
            end
            lut_wr     = ($urandom_range(0, 7) == 0);
            lut_ch     = 2'($urandom);
            lut_addr   = PXW'($urandom);
            lut_data   = PXW'($urandom);
            lut_commit = ($urandom_range(0, 59) == 0);
            bypass     = ($urandom_range(0, 3) == 0);
            tick();
            if (acc_last) beats++;
            cyc++;
        end
        chk("rand_beats", beats, 1000);
        vin.tvalid = 0; lut_wr = 0; lut_commit = 0; bypass = 0; vout.tready = 1;
        drain();
        repeat (4) tick();
        chk("final_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
